// File: rtl/cacheline_arbiter_pkg.sv
// Shared types and helpers for the cacheline arbiter.
// Beat/index width helpers keep degenerate sizes at one bit.
package arb_types;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  localparam bit MODE_FIXED = 1'b0;
  localparam bit MODE_RR    = 1'b1;

  function automatic int beats_of(
    input int line_bits,
    input int burst_bits
  );
    return line_bits / burst_bits;
  endfunction

  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cacheline_arbiter_rr_picker.sv
// Combinational request picker: fixed lowest-index or
// round-robin starting after the last granted client.
module rr_picker
  import arb_types::*;
#(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  input  logic          mode_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  always_comb begin
    int c;
    logic found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    c     = 0;
    for (int k = 0; k < N; k++) begin
      if (mode_i == MODE_RR) c = int'(last_i) + 1 + k;
      else                   c = k;
      if (c >= N) c = c - N;
      if (!found && req_i[c]) begin
        found    = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = IW'(c);
      end
    end
  end

endmodule

// File: rtl/cacheline_arbiter.sv
// N-client cacheline arbiter serialising whole lines into
// memory bursts and returning a one-cycle completion pulse.
module cacheline_arbiter
  import arb_types::*;
#(
  parameter int NUM_CLIENTS = 2,
  parameter int LINE_BITS   = 256,
  parameter int BURST_BITS  = 64,
  parameter int ADDR_BITS   = 32,
  parameter int RR_MODE     = 1,
  localparam int IW = width_of(NUM_CLIENTS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_CLIENTS-1:0]           cl_read,
  input  logic [NUM_CLIENTS-1:0]           cl_write,
  input  logic [NUM_CLIENTS*ADDR_BITS-1:0] cl_address,
  input  logic [NUM_CLIENTS*LINE_BITS-1:0] cl_wdata,
  output logic [NUM_CLIENTS-1:0]           cl_resp,
  output logic [LINE_BITS-1:0]             cl_rdata,
  output logic [IW-1:0]                    grant_id,
  output logic                             busy,
  output logic                             mem_read,
  output logic                             mem_write,
  output logic [ADDR_BITS-1:0]             mem_addr,
  output logic [BURST_BITS-1:0]            mem_wdata,
  input  logic                             mem_resp,
  input  logic [BURST_BITS-1:0]            mem_rdata
);

  localparam int BEATS = beats_of(LINE_BITS, BURST_BITS);
  localparam int BW    = width_of(BEATS);
  localparam int OFF   = $clog2(LINE_BITS / 8);

  arb_state_e state_q, state_d;
  logic [BW-1:0]        beat_q, beat_d;
  logic [IW-1:0]        last_q, last_d;
  logic [IW-1:0]        gid_q, gid_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [LINE_BITS-1:0] line_q, line_d;
  logic [LINE_BITS-1:0] buf_q, buf_d;

  logic [NUM_CLIENTS-1:0] req;
  logic [NUM_CLIENTS-1:0] pick_gnt;
  logic [IW-1:0]          pick_idx;
  logic [ADDR_BITS-1:0]   sel_addr;
  logic [LINE_BITS-1:0]   sel_wdata;
  logic                   last_beat;

  assign req = cl_read | cl_write;

  rr_picker #(
    .N  (NUM_CLIENTS),
    .IW (IW)
  ) u_pick (
    .req_i  (req),
    .last_i (last_q),
    .mode_i (RR_MODE != 0),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx)
  );

  assign sel_addr =
    cl_address[int'(pick_idx)*ADDR_BITS +: ADDR_BITS];
  assign sel_wdata =
    cl_wdata[int'(pick_idx)*LINE_BITS +: LINE_BITS];
  assign last_beat = (beat_q == BW'(BEATS - 1));

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    last_d  = last_q;
    gid_d   = gid_q;
    addr_d  = addr_q;
    line_d  = line_q;
    buf_d   = buf_q;
    unique case (state_q)
      IDLE: begin
        if (|pick_gnt) begin
          gid_d  = pick_idx;
          last_d = pick_idx;
          addr_d = sel_addr;
          addr_d[OFF-1:0] = '0;
          line_d = sel_wdata;
          beat_d = '0;
          // a simultaneous read+write is served as a write
          state_d = (|(cl_write & pick_gnt)) ? WRITE : READ;
        end
      end
      READ, WRITE: begin
        if (mem_resp) begin
          if (state_q == READ)
            buf_d[int'(beat_q)*BURST_BITS +: BURST_BITS] =
              mem_rdata;
          if (last_beat) begin
            beat_d  = '0;
            state_d = DONE;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      last_q  <= IW'(NUM_CLIENTS - 1);
      gid_q   <= '0;
      addr_q  <= '0;
      line_q  <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      last_q  <= last_d;
      gid_q   <= gid_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    cl_resp = '0;
    if (state_q == DONE) cl_resp[gid_q] = 1'b1;
  end

  assign cl_rdata  = buf_q;
  assign grant_id  = gid_q;
  assign busy      = (state_q != IDLE);
  assign mem_read  = (state_q == READ);
  assign mem_write = (state_q == WRITE);
  assign mem_addr  = addr_q;
  assign mem_wdata =
    line_q[int'(beat_q)*BURST_BITS +: BURST_BITS];

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Directed and randomized bench for cacheline_arbiter,
// one round-robin and one fixed-priority instance.
module tb_cacheline_arbiter;

  localparam int N     = 2;
  localparam int LB    = 256;
  localparam int BB    = 64;
  localparam int AB    = 32;
  localparam int BEATS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    rd_a, wr_a, rd_b, wr_b, resp_a, resp_b;
  logic [N*AB-1:0] addr_in;
  logic [N*LB-1:0] wd_in;
  logic [LB-1:0]   rdata_a, rdata_b;
  logic [0:0]      gid_a, gid_b;
  logic            busy_a, busy_b, mr_a, mw_a, mr_b, mw_b;
  logic            mresp_a, mresp_b;
  logic [AB-1:0]   maddr_a, maddr_b;
  logic [BB-1:0]   mwd_a, mwd_b, mrd_a, mrd_b;

  cacheline_arbiter #(
    .NUM_CLIENTS(N), .LINE_BITS(LB), .BURST_BITS(BB),
    .ADDR_BITS(AB), .RR_MODE(1)
  ) dut (
    .clk(clk), .rst(rst),
    .cl_read(rd_a), .cl_write(wr_a),
    .cl_address(addr_in), .cl_wdata(wd_in),
    .cl_resp(resp_a), .cl_rdata(rdata_a),
    .grant_id(gid_a), .busy(busy_a),
    .mem_read(mr_a), .mem_write(mw_a),
    .mem_addr(maddr_a), .mem_wdata(mwd_a),
    .mem_resp(mresp_a), .mem_rdata(mrd_a)
  );

  cacheline_arbiter #(
    .NUM_CLIENTS(N), .LINE_BITS(LB), .BURST_BITS(BB),
    .ADDR_BITS(AB), .RR_MODE(0)
  ) dut_fp (
    .clk(clk), .rst(rst),
    .cl_read(rd_b), .cl_write(wr_b),
    .cl_address(addr_in), .cl_wdata(wd_in),
    .cl_resp(resp_b), .cl_rdata(rdata_b),
    .grant_id(gid_b), .busy(busy_b),
    .mem_read(mr_b), .mem_write(mw_b),
    .mem_addr(maddr_b), .mem_wdata(mwd_b),
    .mem_resp(mresp_b), .mem_rdata(mrd_b)
  );

  typedef struct {
    int             c;
    bit             wr;
    logic [AB-1:0]  a;
    logic [LB-1:0]  line;
  } txn_t;

  int n_assert = 0;
  int n_fail   = 0;
  int gap      = 0;
  bit plain    = 1'b1;
  logic [31:0] seedw = '0;
  int ba = 0, wa = 0, bb = 0, wb = 0;
  logic [BB-1:0] wcap [BEATS];
  logic [AB-1:0] cap_addr = '0;
  bit rand_on = 1'b0;
  bit gen_on  = 1'b0;
  bit cact [N];
  int cdelay [N];
  int last_m = N - 1;
  int done_cnt = 0;
  txn_t q[$];

  task automatic check(input string tag,
                       input logic [LB-1:0] obs,
                       input logic [LB-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [BB-1:0] pat(
    input logic [AB-1:0] a, input int b);
    if (plain) return {16{4'(b + 1)}};
    return {a ^ (32'(b) * 32'h9E3779B9),
            ~a ^ 32'(b) ^ seedw};
  endfunction

  function automatic logic [LB-1:0] expline(
    input logic [AB-1:0] a);
    logic [LB-1:0] l;
    for (int b = 0; b < BEATS; b++) l[b*BB +: BB] = pat(a, b);
    return l;
  endfunction

  function automatic logic [LB-1:0] wline();
    logic [LB-1:0] l;
    for (int b = 0; b < BEATS; b++) l[b*BB +: BB] = wcap[b];
    return l;
  endfunction

  // memory: answers each beat after `gap` idle cycles
  task automatic mem_step(input logic act,
                          input logic [AB-1:0] a,
                          inout int beat, inout int wt,
                          output logic resp,
                          output logic [BB-1:0] rd);
    resp = 1'b0;
    rd   = '0;
    if (!act || rst) begin
      beat = 0;
      wt   = 0;
    end else if (wt < gap) begin
      wt++;
    end else begin
      resp = 1'b1;
      rd   = pat(a, beat);
      beat++;
      wt = 0;
    end
  endtask

  task automatic rand_step();
    if (resp_a != '0) begin
      if (q.size() == 0) begin
        check("rand_spurious_resp", resp_a, '0);
      end else begin
        txn_t t;
        t = q.pop_front();
        check("rand_resp", resp_a, 1 << t.c);
        check("rand_gid", gid_a, t.c);
        check("rand_addr", cap_addr, t.a);
        if (t.wr) check("rand_wline", wline(), t.line);
        else check("rand_rline", rdata_a, expline(t.a));
        rd_a[t.c]   = 1'b0;
        wr_a[t.c]   = 1'b0;
        cact[t.c]   = 1'b0;
        cdelay[t.c] = $urandom_range(2, 5);
        done_cnt++;
      end
    end
    for (int c = 0; c < N; c++) begin
      if (!cact[c] && gen_on) begin
        if (cdelay[c] > 0) begin
          cdelay[c]--;
        end else begin
          int op;
          logic [LB-1:0] ln;
          op = $urandom_range(0, 2);
          for (int w = 0; w < 8; w++) ln[w*32 +: 32] = $urandom;
          addr_in[c*AB +: AB] = $urandom;
          wd_in[c*LB +: LB]   = ln;
          rd_a[c] = (op != 1);
          wr_a[c] = (op != 0);
          cact[c] = 1'b1;
        end
      end
    end
    // winner predicted from the request set the IDLE edge sees
    if (!busy_a && ((rd_a | wr_a) != '0)) begin
      logic [N-1:0] req;
      txn_t t;
      int w;
      req = rd_a | wr_a;
      w = -1;
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (last_m + k) % N;
        if (w < 0 && req[c]) w = c;
      end
      t.c    = w;
      t.wr   = wr_a[w];
      t.a    = {addr_in[w*AB+5 +: AB-5], 5'b0};
      t.line = wd_in[w*LB +: LB];
      q.push_back(t);
      last_m = w;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    mem_step(mr_a | mw_a, maddr_a, ba, wa, mresp_a, mrd_a);
    if (mresp_a) begin
      if (ba >= 1 && ba <= BEATS) wcap[ba-1] = mwd_a;
      cap_addr = maddr_a;
    end
    mem_step(mr_b | mw_b, maddr_b, bb, wb, mresp_b, mrd_b);
    if (rand_on) rand_step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, beats, na, nb;
    int ga [8];
    int gb [8];
    logic [LB-1:0] ln;

    rd_a = '0; wr_a = '0; rd_b = '0; wr_b = '0;
    addr_in = '0; wd_in = '0;
    mresp_a = 1'b0; mresp_b = 1'b0;
    mrd_a = '0; mrd_b = '0;
    for (int c = 0; c < N; c++) begin
      cact[c] = 1'b0;
      cdelay[c] = 0;
    end
    for (int b = 0; b < BEATS; b++) wcap[b] = '0;

    rst = 1'b1;
    repeat (3) cycle();
    check("rst_busy", busy_a, 0);
    check("rst_mem_read", mr_a, 0);
    check("rst_mem_write", mw_a, 0);
    check("rst_mem_addr", maddr_a, 0);
    check("rst_mem_wdata", mwd_a, 0);
    check("rst_cl_resp", resp_a, 0);
    check("rst_cl_rdata", rdata_a, 0);
    check("rst_grant_id", gid_a, 0);
    check("rst_fp_busy", busy_b, 0);
    rst = 1'b0;
    cycle();

    // single read, client 1
    plain = 1'b1;
    gap = 0;
    addr_in[AB +: AB] = 32'h0000_1234;
    rd_a = 2'b10;
    n = 0;
    while (resp_a == '0 && n < 20) begin
      cycle();
      n++;
      if (n == 1) begin
        check("rd_mem_read", mr_a, 1);
        check("rd_mem_write", mw_a, 0);
        check("rd_mem_addr", maddr_a, 32'h0000_1220);
        check("rd_busy", busy_a, 1);
      end
    end
    check("rd_latency", n, BEATS + 1);
    check("rd_resp", resp_a, 2'b10);
    check("rd_gid", gid_a, 1);
    check("rd_rdata", rdata_a,
          {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
           64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
    rd_a = '0;
    cycle();
    check("rd_resp_pulse", resp_a, 0);
    check("rd_idle", busy_a, 0);

    // single write, client 0, 3-cycle gaps between beats
    gap = 3;
    ln = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
          64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    addr_in[0 +: AB] = 32'h0000_8008;
    wd_in[0 +: LB] = ln;
    wr_a = 2'b01;
    n = 0;
    beats = 0;
    while (resp_a == '0 && n < 60) begin
      cycle();
      n++;
      if (resp_a == '0) begin
        check("wr_mem_write", mw_a, 1);
        check("wr_mem_addr", maddr_a, 32'h0000_8000);
        if (beats < BEATS)
          check("wr_mem_wdata", mwd_a, ln[beats*BB +: BB]);
        if (mresp_a) beats++;
      end
    end
    check("wr_beats", beats, BEATS);
    check("wr_latency", n, 4 * BEATS + 1);
    check("wr_resp", resp_a, 2'b01);
    check("wr_line", wline(), ln);
    wr_a = '0;
    cycle();
    check("wr_mem_write_drop", mw_a, 0);

    // read and write together: write wins
    gap = 0;
    for (int w = 0; w < 8; w++) ln[w*32 +: 32] = $urandom;
    addr_in[0 +: AB] = 32'h0000_0040;
    wd_in[0 +: LB] = ln;
    rd_a = 2'b01;
    wr_a = 2'b01;
    cycle();
    check("rw_mem_write", mw_a, 1);
    check("rw_mem_read", mr_a, 0);
    n = 0;
    while (resp_a == '0 && n < 20) begin
      cycle();
      n++;
    end
    check("rw_resp", resp_a, 2'b01);
    check("rw_line", wline(), ln);
    rd_a = '0;
    wr_a = '0;
    cycle();

    // both clients held: RR alternates, fixed stays on 0
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    addr_in = {32'h0000_2000, 32'h0000_1000};
    rd_a = 2'b11;
    rd_b = 2'b11;
    na = 0;
    nb = 0;
    n = 0;
    while ((na < 4 || nb < 4) && n < 100) begin
      cycle();
      n++;
      if (resp_a != '0 && na < 8) begin
        ga[na] = int'(gid_a);
        na++;
      end
      if (resp_b != '0 && nb < 8) begin
        gb[nb] = int'(gid_b);
        nb++;
      end
    end
    rd_a = '0;
    rd_b = '0;
    check("prio_rr_count", na, 4);
    check("prio_fp_count", nb, 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("prio_rr_grant%0d", k), ga[k], k % 2);
      check($sformatf("prio_fp_grant%0d", k), gb[k], 0);
    end
    repeat (3) cycle();

    // reset in the middle of a read burst
    addr_in[0 +: AB] = 32'h0000_0100;
    rd_a = 2'b01;
    n = 0;
    beats = 0;
    while (beats < 2 && n < 20) begin
      cycle();
      n++;
      if (mresp_a) beats++;
    end
    cycle();
    rst = 1'b1;
    cycle();
    check("mrst_mem_read", mr_a, 0);
    check("mrst_busy", busy_a, 0);
    check("mrst_resp", resp_a, 0);
    check("mrst_rdata", rdata_a, 0);
    check("mrst_mem_addr", maddr_a, 0);
    rst = 1'b0;
    n = 0;
    while (resp_a == '0 && n < 20) begin
      cycle();
      n++;
    end
    check("mrst_retry_latency", n, BEATS + 1);
    check("mrst_retry_resp", resp_a, 2'b01);
    check("mrst_retry_rdata", rdata_a, expline(32'h0000_0100));
    rd_a = '0;
    cycle();

    // randomized traffic against the scoreboard
    plain = 1'b0;
    seedw = $urandom;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    last_m = N - 1;
    done_cnt = 0;
    q.delete();
    gen_on = 1'b1;
    rand_on = 1'b1;
    n = 0;
    while (done_cnt < 40 && n < 3000) begin
      gap = $urandom_range(0, 2);
      cycle();
      n++;
    end
    gen_on = 1'b0;
    n = 0;
    while ((q.size() != 0 || cact[0] || cact[1]) && n < 200) begin
      cycle();
      n++;
    end
    rand_on = 1'b0;
    check("rand_done", done_cnt >= 40, 1);
    check("rand_drain", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
